// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the N-channel memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   arb_op_t    : latched downstream operation (read or write)
//   POLICY_*    : grant policy selectors for the POLICY parameter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  localparam int POLICY_FIXED = 0;
  localparam int POLICY_RR    = 1;

endpackage

// File: rtl/arb_grant_sel.sv
// arb_grant_sel: combinational rotated priority encoder.
//   req         : per-channel request vector
//   start_idx   : first index searched when policy_rr is set
//   policy_rr   : 1 = search from start_idx upward (mod NUM_CH), 0 = from index 0
//   grant_idx   : index of the winning channel (0 when nothing requests)
//   grant_valid : high when any channel requests
module arb_grant_sel #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  start_idx,
  input  logic              policy_rr,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [IDX_W-1:0] base;
  logic [IDX_W:0]   cand;

  // Walk the offsets from farthest to nearest so the candidate closest to
  // the search base is the last one written and therefore wins. The extra
  // bit on cand holds base+offset before the modulo wrap.
  always_comb begin
    base        = policy_rr ? start_idx : '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = {1'b0, base} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_CH)) begin
        cand = cand - (IDX_W + 1)'(NUM_CH);
      end
      if (req[cand[IDX_W-1:0]]) begin
        grant_idx   = cand[IDX_W-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: merges NUM_CH cache-side requesters onto one line-memory port.
// One transfer at a time: IDLE picks a winner, BUSY holds the downstream
// request until mem_resp, RESP pulses req_resp for the winner. All outputs
// come straight from flops.
//   clk, reset                 : clock, synchronous active-high reset
//   req_read/req_write         : per-channel request, held until that channel's resp
//   req_address/req_wdata      : per-channel address / write data, packed by channel
//   req_rdata, req_resp        : shared read data and one-hot completion pulse
//   mem_read/mem_write         : downstream request strobes
//   mem_address/mem_wdata      : downstream address / write data
//   mem_rdata, mem_resp        : downstream read data and completion
//   conflict_count             : saturating count of contended arbitrations
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 256,
  parameter int ADDR_W = 32,
  parameter int POLICY = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_read,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_address,
  input  logic [NUM_CH*WIDTH-1:0]  req_wdata,
  output logic [WIDTH-1:0]         req_rdata,
  output logic [NUM_CH-1:0]        req_resp,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata,
  input  logic                     mem_resp,
  output logic [31:0]              conflict_count
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_t state_q, state_d;
  arb_op_t    op_q, op_d;

  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [NUM_CH-1:0] resp_q, resp_d;
  logic [31:0]       conflict_q, conflict_d;

  logic [NUM_CH-1:0] req;
  logic [IDX_W-1:0]  start_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_valid;
  logic              multi_req;

  assign req       = req_read | req_write;
  assign multi_req = ($countones(req) > 1);

  // Round-robin search begins one past the last winner, wrapping to 0.
  assign start_idx = (rr_ptr_q == IDX_W'(NUM_CH - 1)) ? '0 : rr_ptr_q + 1'b1;

  arb_grant_sel #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_grant_sel (
    .req         (req),
    .start_idx   (start_idx),
    .policy_rr   (POLICY == POLICY_RR),
    .grant_idx   (sel_idx),
    .grant_valid (sel_valid)
  );

  // State and datapath registers; reset also aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      grant_q     <= '0;
      rr_ptr_q    <= IDX_W'(NUM_CH - 1);
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      conflict_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      conflict_q  <= conflict_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_valid) state_d = BUSY;
      BUSY:    if (mem_resp)  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and latches. A simultaneous read+write on one channel
  // is treated as a write. In BUSY the strobe is held from the latched op and
  // drops on the same edge that captures mem_rdata.
  always_comb begin
    op_d        = op_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    resp_d      = '0;
    conflict_d  = conflict_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_d     = sel_idx;
          op_d        = req_write[sel_idx] ? OP_WRITE : OP_READ;
          addr_d      = req_address[sel_idx*ADDR_W +: ADDR_W];
          wdata_d     = req_wdata[sel_idx*WIDTH +: WIDTH];
          mem_write_d = req_write[sel_idx];
          mem_read_d  = ~req_write[sel_idx];
          if (POLICY == POLICY_RR) begin
            rr_ptr_d = sel_idx;
          end
          if (multi_req && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_d = conflict_q + 32'd1;
          end
        end
      end
      BUSY: begin
        if (mem_resp) begin
          rdata_d         = mem_rdata;
          resp_d[grant_q] = 1'b1;
        end else begin
          mem_read_d  = (op_q == OP_READ);
          mem_write_d = (op_q == OP_WRITE);
        end
      end
      default: begin
      end
    endcase
  end

  assign req_rdata      = rdata_q;
  assign req_resp       = resp_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = addr_q;
  assign mem_wdata      = wdata_q;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed bench with two arbiter instances, a 2-channel
// fixed-priority one (dut2) and a 3-channel round-robin one (dut3).
module tb_mem_arbiter_n;

  logic clk;

  int errCount   = 0;
  int checkCount = 0;

  // dut2: NUM_CH=2, POLICY=0
  logic         reset2;
  logic [1:0]   req_read2, req_write2;
  logic [63:0]  req_address2;
  logic [511:0] req_wdata2;
  logic [255:0] req_rdata2;
  logic [1:0]   req_resp2;
  logic         mem_read2, mem_write2;
  logic [31:0]  mem_address2;
  logic [255:0] mem_wdata2, mem_rdata2;
  logic         mem_resp2;
  logic [31:0]  conflict2;

  // dut3: NUM_CH=3, POLICY=1
  logic         reset3;
  logic [2:0]   req_read3, req_write3;
  logic [95:0]  req_address3;
  logic [767:0] req_wdata3;
  logic [255:0] req_rdata3;
  logic [2:0]   req_resp3;
  logic         mem_read3, mem_write3;
  logic [31:0]  mem_address3;
  logic [255:0] mem_wdata3, mem_rdata3;
  logic         mem_resp3;
  logic [31:0]  conflict3;

  mem_arbiter_n #(.NUM_CH(2), .WIDTH(256), .ADDR_W(32), .POLICY(0)) dut2 (
    .clk(clk), .reset(reset2),
    .req_read(req_read2), .req_write(req_write2),
    .req_address(req_address2), .req_wdata(req_wdata2),
    .req_rdata(req_rdata2), .req_resp(req_resp2),
    .mem_read(mem_read2), .mem_write(mem_write2),
    .mem_address(mem_address2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .mem_resp(mem_resp2),
    .conflict_count(conflict2)
  );

  mem_arbiter_n #(.NUM_CH(3), .WIDTH(256), .ADDR_W(32), .POLICY(1)) dut3 (
    .clk(clk), .reset(reset3),
    .req_read(req_read3), .req_write(req_write3),
    .req_address(req_address3), .req_wdata(req_wdata3),
    .req_rdata(req_rdata3), .req_resp(req_resp3),
    .mem_read(mem_read3), .mem_write(mem_write3),
    .mem_address(mem_address3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .mem_resp(mem_resp3),
    .conflict_count(conflict3)
  );

  // Free-running clock; the DUTs act on posedge, the bench works on negedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the request side of dut2.
  task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr,
                               input logic [63:0] addr, input logic [511:0] wdata);
    req_read2    = rd;
    req_write2   = wr;
    req_address2 = addr;
    req_wdata2   = wdata;
  endtask

  // Waits (bounded) for dut3 to start a transfer, answers it immediately,
  // then checks the grant. The served channel drops its request in the
  // RESP cycle; channels in 'reraise' come back up during the BUSY cycle.
  task automatic serveChannel3(input string tag, input int expCh,
                               input logic [2:0] reraise);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = mem_read3 | mem_write3;
    end
    checkOutput({tag, "_busy"}, 256'(seen), 256'd1);
    checkOutput({tag, "_addr"}, 256'(mem_address3), 256'(32'h1000 * (expCh + 1)));
    req_read3  = req_read3 | reraise;
    mem_rdata3 = 256'(expCh + 16);
    mem_resp3  = 1'b1;
    @(negedge clk);
    mem_resp3 = 1'b0;
    checkOutput({tag, "_grant"}, 256'(req_resp3), 256'(3'b001 << expCh));
    checkOutput({tag, "_rdata"}, req_rdata3, 256'(expCh + 16));
    req_read3 = req_read3 & ~req_resp3;
  endtask

  initial begin
    reset2 = 1'b1;  reset3 = 1'b1;
    applyStimulus(2'b00, 2'b00, '0, '0);
    mem_rdata2 = '0; mem_resp2 = 1'b0;
    req_read3 = '0; req_write3 = '0;
    req_address3 = {32'h3000, 32'h2000, 32'h1000};
    req_wdata3 = '0;
    mem_rdata3 = '0; mem_resp3 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_read", 256'(mem_read2), 256'd0);
    checkOutput("rst_mem_write", 256'(mem_write2), 256'd0);
    checkOutput("rst_resp", 256'(req_resp2), 256'd0);
    checkOutput("rst_rdata", req_rdata2, 256'd0);
    checkOutput("rst_addr", 256'(mem_address2), 256'd0);
    checkOutput("rst_conflict", 256'(conflict2), 256'd0);
    checkOutput("rst_conflict3", 256'(conflict3), 256'd0);
    reset2 = 1'b0;  reset3 = 1'b0;

    // Test 1: lone ch1 read, memory answers four cycles later
    @(negedge clk);
    applyStimulus(2'b10, 2'b00, {32'h0000_1000, 32'h0}, '0);
    @(negedge clk);
    checkOutput("t1_mem_read_c1", 256'(mem_read2), 256'd1);
    checkOutput("t1_mem_write_c1", 256'(mem_write2), 256'd0);
    checkOutput("t1_addr_c1", 256'(mem_address2), 256'h1000);
    repeat (3) @(negedge clk);
    checkOutput("t1_mem_read_c4", 256'(mem_read2), 256'd1);
    @(negedge clk);
    checkOutput("t1_resp_c5", 256'(req_resp2), 256'd0);
    mem_resp2  = 1'b1;
    mem_rdata2 = {32{8'hA5}};
    @(negedge clk);
    checkOutput("t1_resp_c6", 256'(req_resp2), 256'b10);
    checkOutput("t1_rdata_c6", req_rdata2, {32{8'hA5}});
    checkOutput("t1_mem_read_c6", 256'(mem_read2), 256'd0);
    mem_resp2  = 1'b0;
    mem_rdata2 = '0;
    applyStimulus(2'b00, 2'b00, '0, '0);
    @(negedge clk);
    checkOutput("t1_resp_c7", 256'(req_resp2), 256'd0);
    checkOutput("t1_rdata_hold", req_rdata2, {32{8'hA5}});
    checkOutput("t1_conflict", 256'(conflict2), 256'd0);

    // Test 2: ch0 read vs ch1 write together, ch0 wins first
    applyStimulus(2'b01, 2'b10, {32'h80, 32'h40}, {256'h1234, 256'hDEAD});
    @(negedge clk);
    checkOutput("t2_read0", 256'(mem_read2), 256'd1);
    checkOutput("t2_write0", 256'(mem_write2), 256'd0);
    checkOutput("t2_addr0", 256'(mem_address2), 256'h40);
    checkOutput("t2_conflict_a", 256'(conflict2), 256'd1);
    mem_resp2  = 1'b1;
    mem_rdata2 = 256'h5555;
    @(negedge clk);
    checkOutput("t2_resp0", 256'(req_resp2), 256'b01);
    checkOutput("t2_rdata0", req_rdata2, 256'h5555);
    mem_resp2 = 1'b0;
    applyStimulus(2'b00, 2'b10, {32'h80, 32'h40}, {256'h1234, 256'hDEAD});
    @(negedge clk);
    checkOutput("t2_idle_write", 256'(mem_write2), 256'd0);
    @(negedge clk);
    checkOutput("t2_write1", 256'(mem_write2), 256'd1);
    checkOutput("t2_read1", 256'(mem_read2), 256'd0);
    checkOutput("t2_addr1", 256'(mem_address2), 256'h80);
    checkOutput("t2_wdata1", mem_wdata2, 256'h1234);
    mem_resp2  = 1'b1;
    mem_rdata2 = 256'h77;
    @(negedge clk);
    checkOutput("t2_resp1", 256'(req_resp2), 256'b10);
    checkOutput("t2_rdata1", req_rdata2, 256'h77);
    checkOutput("t2_conflict_b", 256'(conflict2), 256'd1);
    mem_resp2 = 1'b0;
    applyStimulus(2'b00, 2'b00, '0, '0);

    // Test 5: reset in BUSY aborts the transfer; a late mem_resp is ignored
    @(negedge clk);
    applyStimulus(2'b01, 2'b00, {32'h0, 32'h200}, '0);
    @(negedge clk);
    checkOutput("t5_busy", 256'(mem_read2), 256'd1);
    reset2 = 1'b1;
    applyStimulus(2'b00, 2'b00, '0, '0);
    @(negedge clk);
    checkOutput("t5_mem_read", 256'(mem_read2), 256'd0);
    checkOutput("t5_resp", 256'(req_resp2), 256'd0);
    checkOutput("t5_conflict", 256'(conflict2), 256'd0);
    checkOutput("t5_addr", 256'(mem_address2), 256'd0);
    reset2     = 1'b0;
    mem_resp2  = 1'b1;
    mem_rdata2 = 256'hBAD;
    @(negedge clk);
    checkOutput("t5_late_resp", 256'(req_resp2), 256'd0);
    checkOutput("t5_late_rdata", req_rdata2, 256'd0);
    checkOutput("t5_late_read", 256'(mem_read2), 256'd0);
    mem_resp2 = 1'b0;
    @(negedge clk);
    checkOutput("t5_still_idle", 256'(req_resp2), 256'd0);

    // Test 6: read and write on the same channel is a write
    applyStimulus(2'b10, 2'b10, {32'h300, 32'h0}, {{8{32'hCAFE_F00D}}, 256'h0});
    @(negedge clk);
    checkOutput("t6_write", 256'(mem_write2), 256'd1);
    checkOutput("t6_read", 256'(mem_read2), 256'd0);
    checkOutput("t6_addr", 256'(mem_address2), 256'h300);
    checkOutput("t6_wdata", mem_wdata2, {8{32'hCAFE_F00D}});
    mem_resp2 = 1'b1;
    @(negedge clk);
    checkOutput("t6_resp", 256'(req_resp2), 256'b10);
    mem_resp2 = 1'b0;
    applyStimulus(2'b00, 2'b00, '0, '0);

    // Test 3: three channels requesting continuously, round-robin order
    req_read3 = 3'b111;
    serveChannel3("t3_g0", 0, 3'b000);
    serveChannel3("t3_g1", 1, 3'b001);
    serveChannel3("t3_g2", 2, 3'b010);
    serveChannel3("t3_g3", 0, 3'b100);
    serveChannel3("t3_g4", 1, 3'b001);
    serveChannel3("t3_g5", 2, 3'b010);
    req_read3 = 3'b000;
    @(negedge clk);
    checkOutput("t3_conflict", 256'(conflict3), 256'd6);

    // Test 4: ch2 twice, then ch0+ch2 -> pointer wraps to ch0
    reset3 = 1'b1;
    @(negedge clk);
    reset3    = 1'b0;
    req_read3 = 3'b100;
    serveChannel3("t4_g0", 2, 3'b000);
    repeat (2) @(negedge clk);
    req_read3 = 3'b100;
    serveChannel3("t4_g1", 2, 3'b000);
    repeat (2) @(negedge clk);
    req_read3 = 3'b101;
    serveChannel3("t4_g2", 0, 3'b000);
    req_read3 = 3'b000;
    @(negedge clk);
    checkOutput("t4_conflict", 256'(conflict3), 256'd1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
